// File: rtl/counter_ctrl_if.sv
// CPU I/O bus seen by counter_ctrl: single-cycle read/write strobes on a 2-bit register address.
// The master drives strobes and write data; the slave returns registered read data.
interface counter_ctrl_if;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output re, output addr, output wdata, input rdata);
    modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

// File: rtl/counter_ctrl.sv
// MMIO controller that loads and monitors an external down-counter in the clk0 domain.
// Supports one-shot and periodic modes and raises a maskable expiry interrupt.
module counter_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ARM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_ctrl_if.slave        io,
    output logic                 cnt_we,
    output logic [31:0]          cnt_val,
    input  logic                 cnt_expired,
    input  logic [31:0]          cnt_value,
    output logic                 irq
);

    localparam int unsigned TW = $clog2(ARM_TIMEOUT + 1);

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrLoad   = 2'd1;
    localparam logic [1:0] AddrStatus = 2'd2;
    localparam logic [1:0] AddrCount  = 2'd3;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StArm  = 3'd2,
        StRun  = 3'd3,
        StExp  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   en_q, en_d;
    logic                   auto_q, auto_d;
    logic                   ie_q, ie_d;
    logic [31:0]            load_q, load_d;
    logic                   pend_q, pend_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic [TW-1:0]          arm_cnt_q, arm_cnt_d;
    logic                   cnt_we_q, cnt_we_d;
    logic [31:0]            cnt_val_q, cnt_val_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   irq_q, irq_d;
    logic [SYNC_STAGES-1:0] exp_sync_q, exp_sync_d;
    logic [31:0]            count_s1_q, count_s1_d;
    logic [31:0]            count_s2_q, count_s2_d;

    logic ctrl_wr, load_wr, status_wr, disable_wr, expired;

    assign ctrl_wr    = io.we && (io.addr == AddrCtrl);
    assign load_wr    = io.we && (io.addr == AddrLoad);
    assign status_wr  = io.we && (io.addr == AddrStatus);
    assign disable_wr = ctrl_wr && !io.wdata[0];
    assign expired    = exp_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        load_d     = load_q;
        pend_d     = pend_q;
        err_d      = err_q;
        start_d    = 1'b0;
        arm_cnt_d  = arm_cnt_q;
        cnt_we_d   = 1'b0;
        cnt_val_d  = cnt_val_q;
        rdata_d    = rdata_q;
        exp_sync_d = {exp_sync_q[SYNC_STAGES-2:0], cnt_expired};
        count_s1_d = cnt_value;
        count_s2_d = count_s1_q;

        if (ctrl_wr) begin
            en_d    = io.wdata[0];
            auto_d  = io.wdata[1];
            ie_d    = io.wdata[2];
            start_d = io.wdata[0] && !en_q;
        end
        if (load_wr) begin
            load_d = io.wdata;
        end
        // Software clears are applied first so that hardware sets below win.
        if (status_wr) begin
            if (io.wdata[0]) pend_d = 1'b0;
            if (io.wdata[2]) err_d = 1'b0;
        end

        if (disable_wr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_q) begin
                        if (load_q == 32'd0) begin
                            err_d = 1'b1;
                            en_d  = 1'b0;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
                StLoad: begin
                    state_d   = StArm;
                    arm_cnt_d = '0;
                end
                StArm: begin
                    if (!expired) begin
                        state_d = StRun;
                    end else if (arm_cnt_q == TW'(ARM_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        en_d    = 1'b0;
                        state_d = StIdle;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    // PEND is raised on entry to EXP and held through it.
                    if (expired) begin
                        state_d = StExp;
                        pend_d  = 1'b1;
                    end
                end
                StExp: begin
                    pend_d = 1'b1;
                    if (auto_q && en_q) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                        en_d    = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_d == StLoad) begin
            cnt_we_d  = 1'b1;
            cnt_val_d = load_d;
        end

        if (io.re) begin
            unique case (io.addr)
                AddrCtrl:   rdata_d = {29'd0, ie_q, auto_q, en_q};
                AddrLoad:   rdata_d = load_q;
                AddrStatus: rdata_d = {26'd0, state_q, err_q, (state_q != StIdle), pend_q};
                AddrCount:  rdata_d = count_s2_q;
                default:    rdata_d = 32'd0;
            endcase
        end

        irq_d = pend_q && ie_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            load_q     <= 32'd0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            arm_cnt_q  <= '0;
            cnt_we_q   <= 1'b0;
            cnt_val_q  <= 32'd0;
            rdata_q    <= 32'd0;
            irq_q      <= 1'b0;
            exp_sync_q <= '0;
            count_s1_q <= 32'd0;
            count_s2_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            load_q     <= load_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            start_q    <= start_d;
            arm_cnt_q  <= arm_cnt_d;
            cnt_we_q   <= cnt_we_d;
            cnt_val_q  <= cnt_val_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            exp_sync_q <= exp_sync_d;
            count_s1_q <= count_s1_d;
            count_s2_q <= count_s2_d;
        end
    end

    assign io.rdata = rdata_q;
    assign cnt_we   = cnt_we_q;
    assign cnt_val  = cnt_val_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: behavioural down-counter model, read/load scoreboards checked by a monitor.
// Scenarios cover one-shot, periodic, zero load, arm timeout, disable, races and reset.
module tb_counter_ctrl;

    localparam logic [1:0] A_CTRL = 2'd0, A_LOAD = 2'd1, A_STATUS = 2'd2, A_COUNT = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_we;
    logic [31:0] cnt_val;
    logic        cnt_expired;
    logic [31:0] cnt_value;
    logic        irq;

    always #5 clk = ~clk;

    counter_ctrl_if io ();

    counter_ctrl #(
        .SYNC_STAGES (2),
        .ARM_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (io),
        .cnt_we      (cnt_we),
        .cnt_val     (cnt_val),
        .cnt_expired (cnt_expired),
        .cnt_value   (cnt_value),
        .irq         (irq)
    );

    // Down-counter model: expired is high whenever the count sits at zero.
    logic [31:0] m_cnt;
    logic        m_exp;
    logic        tie_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 32'd0;
            m_exp <= 1'b1;
        end else if (cnt_we) begin
            m_cnt <= cnt_val;
            m_exp <= (cnt_val == 32'd0);
        end else if (m_cnt != 32'd0) begin
            m_cnt <= m_cnt - 32'd1;
            if (m_cnt == 32'd1) m_exp <= 1'b1;
        end
    end

    assign cnt_expired = m_exp | tie_exp;
    assign cnt_value   = m_cnt;

    int          tests = 0;
    int          fails = 0;
    int          loads_seen = 0;
    logic [31:0] exp_load_q[$];
    logic [31:0] exp_rd_q[$];
    string       rd_name_q[$];
    logic        chk_en = 1'b0;
    logic        chk_pend = 1'b0;
    logic [31:0] mon_e;
    string       mon_n;

    always @(posedge clk) chk_pend <= io.re && chk_en;

    always @(negedge clk) begin
        if (chk_pend) begin
            tests++;
            if (exp_rd_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected got=%h", io.rdata);
            end else begin
                mon_e = exp_rd_q.pop_front();
                mon_n = rd_name_q.pop_front();
                if (io.rdata !== mon_e) begin
                    fails++;
                    $display("FAIL %s got=%h exp=%h", mon_n, io.rdata, mon_e);
                end
            end
        end
        if (cnt_we === 1'b1) begin
            loads_seen++;
            tests++;
            if (exp_load_q.size() == 0) begin
                fails++;
                $display("FAIL cnt_we_unexpected got_val=%0d exp=no_pulse", cnt_val);
            end else begin
                mon_e = exp_load_q.pop_front();
                if (cnt_val !== mon_e) begin
                    fails++;
                    $display("FAIL cnt_val got=%0d exp=%0d", cnt_val, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        io.we = 1'b1; io.addr = a; io.wdata = d;
        @(negedge clk);
        io.we = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string name);
        @(negedge clk);
        io.re = 1'b1; io.addr = a; chk_en = 1'b1;
        exp_rd_q.push_back(e);
        rd_name_q.push_back(name);
        @(negedge clk);
        io.re = 1'b0; chk_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_loads(input int n, input int budget);
        int b = 0;
        while (loads_seen < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("wait_loads", 32'(loads_seen >= n), 32'd1);
    endtask

    task automatic wait_exp(input logic v, input int budget);
        int b = 0;
        while (m_exp !== v && b < budget) begin
            @(negedge clk);
            b++;
        end
        check("wait_expiry", {31'd0, m_exp}, {31'd0, v});
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] l;
        logic        ie;
        int          base;
        io.we = 1'b0; io.re = 1'b0; io.addr = 2'd0; io.wdata = 32'd0;
        tie_exp = 1'b0;

        // Reset state
        wait_cycles(3);
        check("rst_cnt_we", {31'd0, cnt_we}, 32'd0);
        check("rst_cnt_val", cnt_val, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", io.rdata, 32'd0);
        rst = 1'b0;
        rd_chk(A_CTRL, 32'd0, "rst_ctrl");
        rd_chk(A_LOAD, 32'd0, "rst_load");
        rd_chk(A_STATUS, 32'd0, "rst_status");
        rd_chk(A_COUNT, 32'd0, "rst_count");

        // T1 one-shot
        l = $urandom_range(4, 30);
        exp_load_q.push_back(l);
        bus_wr(A_LOAD, l);
        bus_wr(A_CTRL, 32'h1);
        wait_loads(1, 10);
        wait_cycles(l + 12);
        rd_chk(A_STATUS, 32'h1, "t1_status");
        rd_chk(A_CTRL, 32'h0, "t1_ctrl");
        rd_chk(A_LOAD, l, "t1_load");
        rd_chk(A_COUNT, 32'd0, "t1_count");
        check("t1_irq", {31'd0, irq}, 32'd0);
        bus_wr(A_STATUS, 32'h1);
        rd_chk(A_STATUS, 32'h0, "t1_pend_clr");

        // T3 zero load
        bus_wr(A_LOAD, 32'd0);
        bus_wr(A_CTRL, 32'h1);
        wait_cycles(5);
        rd_chk(A_STATUS, 32'h4, "t3_status");
        rd_chk(A_CTRL, 32'h0, "t3_ctrl");
        bus_wr(A_STATUS, 32'h4);
        rd_chk(A_STATUS, 32'h0, "t3_err_clr");

        // T2 periodic with irq, LOAD changed at the second expiry
        base = loads_seen;
        l = $urandom_range(4, 12);
        exp_load_q.push_back(l);
        exp_load_q.push_back(l);
        exp_load_q.push_back(32'd20);
        bus_wr(A_LOAD, l);
        bus_wr(A_CTRL, 32'h7);
        wait_loads(base + 2, 100);
        @(negedge clk);
        check("t2_irq_after_exp1", {31'd0, irq}, 32'd1);
        wait_exp(1'b0, 10);
        wait_exp(1'b1, 40);
        bus_wr(A_LOAD, 32'd20);
        wait_loads(base + 3, 20);
        bus_wr(A_CTRL, 32'h4);
        check("t2_irq_held", {31'd0, irq}, 32'd1);
        rd_chk(A_STATUS, 32'h1, "t2_status");
        bus_wr(A_STATUS, 32'h1);
        wait_cycles(2);
        check("t2_irq_cleared", {31'd0, irq}, 32'd0);

        // T4 arm timeout
        tie_exp = 1'b1;
        exp_load_q.push_back(32'd3);
        bus_wr(A_LOAD, 32'd3);
        bus_wr(A_CTRL, 32'h1);
        wait_cycles(30);
        rd_chk(A_STATUS, 32'h12, "t4_in_arm");
        wait_cycles(50);
        rd_chk(A_STATUS, 32'h4, "t4_status");
        rd_chk(A_CTRL, 32'h0, "t4_ctrl");
        tie_exp = 1'b0;
        bus_wr(A_STATUS, 32'h4);

        // T5 disable mid-run
        exp_load_q.push_back(32'd60);
        bus_wr(A_LOAD, 32'd60);
        bus_wr(A_CTRL, 32'h3);
        wait_loads(loads_seen + 1, 10);
        wait_cycles(10);
        rd_chk(A_STATUS, 32'h1A, "t5_running");
        bus_wr(A_CTRL, 32'h0);
        rd_chk(A_STATUS, 32'h0, "t5_idle");
        wait_cycles(70);
        rd_chk(A_STATUS, 32'h0, "t5_no_pend");

        // T6 STATUS clear in the EXP cycle: set wins
        l = $urandom_range(5, 15);
        exp_load_q.push_back(l);
        bus_wr(A_LOAD, l);
        bus_wr(A_CTRL, 32'h1);
        wait_loads(loads_seen + 1, 10);
        wait_exp(1'b0, 5);
        wait_exp(1'b1, 40);
        wait_cycles(2);
        bus_wr(A_STATUS, 32'h1);
        rd_chk(A_STATUS, 32'h1, "t6_pend_race");

        // T6 reset during ARM
        tie_exp = 1'b1;
        exp_load_q.push_back(32'd7);
        bus_wr(A_LOAD, 32'd7);
        bus_wr(A_CTRL, 32'h5);
        wait_loads(loads_seen + 1, 10);
        wait_cycles(5);
        check("t6_pre_cnt_val", cnt_val, 32'd7);
        check("t6_pre_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_cnt_we", {31'd0, cnt_we}, 32'd0);
        check("t6_rst_cnt_val", cnt_val, 32'd0);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        check("t6_rst_rdata", io.rdata, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        tie_exp = 1'b0;
        rd_chk(A_STATUS, 32'h0, "t6_status");
        rd_chk(A_CTRL, 32'h0, "t6_ctrl");
        rd_chk(A_LOAD, 32'h0, "t6_load");

        // Same-cycle read and write returns the old value
        bus_wr(A_LOAD, 32'h55);
        @(negedge clk);
        io.we = 1'b1; io.re = 1'b1; io.addr = A_LOAD; io.wdata = 32'hAA; chk_en = 1'b1;
        exp_rd_q.push_back(32'h55);
        rd_name_q.push_back("rw_same_old");
        @(negedge clk);
        io.we = 1'b0; io.re = 1'b0; chk_en = 1'b0;
        rd_chk(A_LOAD, 32'hAA, "rw_same_new");

        // Random one-shots
        for (int i = 0; i < 4; i++) begin
            l  = $urandom_range(3, 20);
            ie = 1'($urandom_range(0, 1));
            exp_load_q.push_back(l);
            bus_wr(A_LOAD, l);
            bus_wr(A_CTRL, {29'd0, ie, 2'b01});
            wait_loads(loads_seen + 1, 10);
            wait_cycles(l + 12);
            rd_chk(A_STATUS, 32'h1, "rnd_status");
            rd_chk(A_CTRL, {29'd0, ie, 2'b00}, "rnd_ctrl");
            check("rnd_irq", {31'd0, irq}, {31'd0, ie});
            bus_wr(A_STATUS, 32'h1);
            rd_chk(A_STATUS, 32'h0, "rnd_clr");
        end

        wait_cycles(3);
        check("load_queue_drained", exp_load_q.size(), 32'd0);
        check("rd_queue_drained", exp_rd_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
